// File: rtl/misc_v_mem_pkg.sv
// Shared memory-subsystem definitions for the CPU, the unified memory and
// the IF/MEM port arbiter: bus widths, the default memory-mapped I/O word
// address, the starvation limit and the arbiter owner encoding.
package misc_v_mem_pkg;

    localparam int unsigned MEM_ADDR_W         = 16;
    localparam int unsigned MEM_DATA_W         = 16;
    localparam logic [15:0] IO_ADDR_DEFAULT    = 16'hFFFF;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    // Which requester owns the memory response in the following cycle.
    // IO accesses are tracked separately because they can coexist with an
    // IF memory grant in the same cycle.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IF     = 2'd1,
        OWN_DM_MEM = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_streak.sv
// Saturating streak counter for the memory port arbiter.
// Counts consecutive MEM-stage memory grants while a fetch is waiting.
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   inc     in   increment (saturates at MAX)
//   clr     in   clear to zero (takes priority over inc)
//   at_max  out  count equals MAX
module arb_streak_counter #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;

    assign at_max = (cnt_q == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the single-ported unified memory between instruction
// fetch (IF) and load/store (MEM). The MEM stage normally wins; after
// STARVE_MAX consecutive MEM grants with a fetch waiting, the fetch is forced
// through. Data word IO_ADDR maps to io_in/io_out and never uses the memory
// port, so an IO access can be granted alongside a fetch.
//   clk, reset                        clock, async active-high reset
//   if_req/if_addr                    fetch request
//   if_stall/if_valid/if_rdata        fetch stall, response pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata     load/store request
//   dm_stall/dm_valid/dm_rdata        load/store stall, response pulse, data
//   mem_en/mem_we/mem_addr/mem_wdata  memory macro command (all 0 when idle)
//   mem_rdata                         memory read data, cycle after mem_en
//   io_in/io_out                      external input port / output register
module mem_port_arbiter
    import misc_v_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W     = MEM_ADDR_W,
    parameter int unsigned       DATA_W     = MEM_DATA_W,
    parameter logic [ADDR_W-1:0] IO_ADDR    = ADDR_W'(IO_ADDR_DEFAULT),
    parameter int unsigned       STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_stall,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out
);

    owner_e            owner_q, owner_d;
    logic              io_pend_q;
    logic              dm_we_q;
    logic [DATA_W-1:0] io_rdata_q;

    logic dm_io, dm_mem;
    logic if_grant, dm_mem_grant, dm_io_grant, dm_grant;
    logic at_max, streak_inc, streak_clr;

    arb_streak_counter #(
        .MAX (STARVE_MAX)
    ) u_streak (
        .clk    (clk),
        .rst    (reset),
        .inc    (streak_inc),
        .clr    (streak_clr),
        .at_max (at_max)
    );

    // Grant and memory command; no grants at all while reset is held.
    always_comb begin
        dm_io        = dm_req & (dm_addr == IO_ADDR);
        dm_mem       = dm_req & ~dm_io;
        if_grant     = ~reset & if_req & (~dm_mem | at_max);
        dm_mem_grant = ~reset & dm_mem & ~(if_req & at_max);
        dm_io_grant  = ~reset & dm_io;
        dm_grant     = dm_mem_grant | dm_io_grant;

        if_stall = if_req & ~if_grant;
        dm_stall = dm_req & ~dm_grant;

        streak_inc = dm_mem_grant & if_req & ~if_grant;
        streak_clr = if_grant | ~if_req;

        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner_d   = OWN_NONE;
        if (if_grant) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
            owner_d  = OWN_IF;
        end else if (dm_mem_grant) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            owner_d   = OWN_DM_MEM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= OWN_NONE;
            io_pend_q  <= 1'b0;
            dm_we_q    <= 1'b0;
            io_rdata_q <= '0;
            io_out     <= '0;
        end else begin
            owner_q   <= owner_d;
            io_pend_q <= dm_io_grant;
            dm_we_q   <= dm_grant & dm_we;
            if (dm_io_grant && !dm_we) begin
                io_rdata_q <= io_in;
            end
            if (dm_io_grant && dm_we) begin
                io_out <= dm_wdata;
            end
        end
    end

    // Responses appear the cycle after the grant; data is zero otherwise.
    always_comb begin
        if_valid = (owner_q == OWN_IF);
        if_rdata = if_valid ? mem_rdata : '0;
        dm_valid = (owner_q == OWN_DM_MEM) | io_pend_q;
        dm_rdata = '0;
        if (!dm_we_q) begin
            if (owner_q == OWN_DM_MEM) begin
                dm_rdata = mem_rdata;
            end else if (io_pend_q) begin
                dm_rdata = io_rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are compared on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_stall, if_valid;
    logic [15:0] if_rdata;
    logic        dm_req, dm_we;
    logic [15:0] dm_addr, dm_wdata;
    logic        dm_stall, dm_valid;
    logic [15:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] io_in, io_out;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .IO_ADDR    (16'hFFFF),
        .STARVE_MAX (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_stall  (if_stall),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_stall  (dm_stall),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .io_in     (io_in),
        .io_out    (io_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        io_in  = '0;
        if_req = 1'b1;
        sample();
        chk("rst_mem_en",   32'(mem_en),   32'd0);
        chk("rst_if_stall", 32'(if_stall), 32'd1);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_dm_valid", 32'(dm_valid), 32'd0);
        chk("rst_io_out",   32'(io_out),   32'd0);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        next_cycle();

        // 1: lone fetch
        if_req = 1'b1; if_addr = 16'h0010;
        sample();
        chk("t1_mem_en",   32'(mem_en),   32'd1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0010);
        chk("t1_mem_we",   32'(mem_we),   32'd0);
        chk("t1_if_stall", 32'(if_stall), 32'd0);
        next_cycle();
        idle_inputs(); mem_rdata = 16'hBEEF;
        sample();
        chk("t1_if_valid", 32'(if_valid), 32'd1);
        chk("t1_if_rdata", 32'(if_rdata), 32'hBEEF);
        chk("t1_idle_en",  32'(mem_en),   32'd0);
        chk("t1_dm_valid", 32'(dm_valid), 32'd0);

        // 2: simultaneous fetch and load, load wins
        next_cycle();
        idle_inputs();
        if_req = 1'b1; if_addr = 16'h0020;
        dm_req = 1'b1; dm_addr = 16'h0200;
        sample();
        chk("t2_mem_addr", 32'(mem_addr), 32'h0200);
        chk("t2_if_stall", 32'(if_stall), 32'd1);
        chk("t2_dm_stall", 32'(dm_stall), 32'd0);
        next_cycle();
        dm_req = 1'b0; mem_rdata = 16'h1234;
        sample();
        chk("t2_dm_valid",  32'(dm_valid), 32'd1);
        chk("t2_dm_rdata",  32'(dm_rdata), 32'h1234);
        chk("t2_if_addr",   32'(mem_addr), 32'h0020);
        chk("t2_if_stall2", 32'(if_stall), 32'd0);
        next_cycle();
        idle_inputs(); mem_rdata = 16'h5678;
        sample();
        chk("t2_if_valid",  32'(if_valid), 32'd1);
        chk("t2_if_rdata",  32'(if_rdata), 32'h5678);
        chk("t2_dm_valid2", 32'(dm_valid), 32'd0);

        // 3: starvation limit, grant order D,D,D,D,I,D,D,D
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            idle_inputs();
            if_req = 1'b1; if_addr = 16'h0040;
            dm_req = 1'b1; dm_addr = 16'h0300;
            sample();
            chk($sformatf("t3_if_stall_%0d", i), 32'(if_stall), (i == 4) ? 32'd0 : 32'd1);
            chk($sformatf("t3_mem_addr_%0d", i), 32'(mem_addr), (i == 4) ? 32'h0040 : 32'h0300);
        end
        next_cycle();
        idle_inputs(); mem_rdata = 16'h0A0A;
        sample();
        chk("t3_dm_valid", 32'(dm_valid), 32'd1);
        chk("t3_if_valid", 32'(if_valid), 32'd0);

        // 4: IO store alongside a fetch
        next_cycle();
        idle_inputs();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'hFFFF; dm_wdata = 16'h0003;
        if_req = 1'b1; if_addr = 16'h0004;
        sample();
        chk("t4_mem_en",    32'(mem_en),   32'd1);
        chk("t4_mem_addr",  32'(mem_addr), 32'h0004);
        chk("t4_mem_we",    32'(mem_we),   32'd0);
        chk("t4_if_stall",  32'(if_stall), 32'd0);
        chk("t4_dm_stall",  32'(dm_stall), 32'd0);
        chk("t4_io_before", 32'(io_out),   32'd0);
        next_cycle();
        idle_inputs(); mem_rdata = 16'h7777;
        sample();
        chk("t4_io_out",   32'(io_out),   32'h0003);
        chk("t4_dm_valid", 32'(dm_valid), 32'd1);
        chk("t4_if_valid", 32'(if_valid), 32'd1);
        chk("t4_dm_rdata", 32'(dm_rdata), 32'd0);

        // 5: IO load samples io_in at the grant edge
        next_cycle();
        idle_inputs();
        io_in = 16'h0003;
        dm_req = 1'b1; dm_addr = 16'hFFFF;
        sample();
        chk("t5_mem_en",   32'(mem_en),   32'd0);
        chk("t5_dm_stall", 32'(dm_stall), 32'd0);
        next_cycle();
        idle_inputs(); io_in = 16'h0055; mem_rdata = 16'h9999;
        sample();
        chk("t5_dm_valid", 32'(dm_valid), 32'd1);
        chk("t5_dm_rdata", 32'(dm_rdata), 32'h0003);

        // 6: reset during an outstanding fetch
        next_cycle();
        idle_inputs();
        if_req = 1'b1; if_addr = 16'h0008;
        sample();
        chk("t6_grant", 32'(mem_en), 32'd1);
        next_cycle();
        reset = 1'b1; mem_rdata = 16'hDEAD;
        sample();
        chk("t6_if_valid", 32'(if_valid), 32'd0);
        chk("t6_io_out",   32'(io_out),   32'd0);
        chk("t6_mem_en",   32'(mem_en),   32'd0);
        chk("t6_if_stall", 32'(if_stall), 32'd1);
        next_cycle();
        reset = 1'b0;
        sample();
        chk("t6_rel_valid", 32'(if_valid), 32'd0);
        chk("t6_rel_grant", 32'(mem_en),   32'd1);
        next_cycle();
        idle_inputs(); mem_rdata = 16'h4242;
        sample();
        chk("t6_post_valid", 32'(if_valid), 32'd1);
        chk("t6_post_rdata", 32'(if_rdata), 32'h4242);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
